// File: rtl/std_bitvec_index_serializer_if.sv
`default_nettype none
// ==========================================================================
// std_bitvec_index_serializer_if : vector-in / index-out handshake bundle
//   (o_remaining exists only with STD_BITVEC_SERIALIZER_POPCOUNT_EN). Rev 1.0
// ==========================================================================
interface std_bitvec_index_serializer_if #(
   parameter int WIDTH = 256
);
   localparam int INDEX_WIDTH = $clog2(WIDTH);

   logic                   i_valid;
   logic                   o_ready;
   logic [WIDTH-1:0]       i_vec;
   logic                   o_valid;
   logic                   i_ready;
   logic [INDEX_WIDTH-1:0] o_index;
   logic                   o_last;
   logic                   o_empty;
`ifdef STD_BITVEC_SERIALIZER_POPCOUNT_EN
   logic [INDEX_WIDTH:0]   o_remaining;
`endif

   // master is the serializer itself; slave is the surrounding logic
   modport master (
      input  i_valid,
      input  i_vec,
      input  i_ready,
`ifdef STD_BITVEC_SERIALIZER_POPCOUNT_EN
      output o_remaining,
`endif
      output o_ready,
      output o_valid,
      output o_index,
      output o_last,
      output o_empty
   );

   modport slave (
      output i_valid,
      output i_vec,
      output i_ready,
`ifdef STD_BITVEC_SERIALIZER_POPCOUNT_EN
      input  o_remaining,
`endif
      input  o_ready,
      input  o_valid,
      input  o_index,
      input  o_last,
      input  o_empty
   );
endinterface
`default_nettype wire

// File: rtl/std_bitvec_index_serializer.sv
`default_nettype none
// ==========================================================================
// std_bitvec_index_serializer : emits the index of every set bit of a vector,
//   one per beat. Optional macro STD_BITVEC_SERIALIZER_POPCOUNT_EN. Rev 1.0
// ==========================================================================
module std_bitvec_index_serializer #(
   parameter int WIDTH     = 256,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   std_bitvec_index_serializer_if.master  bus
);
   localparam int INDEX_WIDTH = $clog2(WIDTH);
   localparam int CNT_WIDTH   = INDEX_WIDTH + 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [WIDTH-1:0]       pending;
   logic [WIDTH-1:0]       pending_nxt;
   logic                   empty_q;
   logic                   empty_nxt;
   logic [INDEX_WIDTH-1:0] index;
   logic                   busy;
   logic                   multi;
   logic                   last;
   logic                   ready;
   logic                   in_hs;
   logic                   out_hs;

   generate
      if (MSB_FIRST) begin : g_msb_first
         always_comb begin
            index = '0;
            for (int i = 0; i < WIDTH; i++) begin
               if (pending[i]) index = INDEX_WIDTH'(i);
            end
         end
      end else begin : g_lsb_first
         always_comb begin
            index = '0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
               if (pending[i]) index = INDEX_WIDTH'(i);
            end
         end
      end
   endgenerate

   // x & (x-1) is nonzero exactly when two or more bits are set
   assign multi  = |(pending & (pending - WIDTH'(1)));
   assign busy   = (state == BUSY);
   assign last   = busy & ~multi;
   assign ready  = ~busy | (bus.i_ready & last);
   assign in_hs  = bus.i_valid & ready;
   assign out_hs = busy & bus.i_ready;

   assign bus.o_valid = busy;
   assign bus.o_ready = ready;
   assign bus.o_index = index;
   assign bus.o_last  = last;
   assign bus.o_empty = empty_q;

   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      empty_nxt   = empty_q;
      if (out_hs) begin
         pending_nxt = pending & ~(WIDTH'(1) << index);
         if (last) begin
            state_nxt = IDLE;
            empty_nxt = 1'b0;
         end
      end
      // A new vector overrides the final-beat retirement for zero-bubble reload
      if (in_hs) begin
         state_nxt   = BUSY;
         pending_nxt = bus.i_vec;
         empty_nxt   = (bus.i_vec == '0);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         pending <= '0;
         empty_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         pending <= pending_nxt;
         empty_q <= empty_nxt;
      end
   end

`ifdef STD_BITVEC_SERIALIZER_POPCOUNT_EN
   logic [CNT_WIDTH-1:0] remaining;
   logic [CNT_WIDTH-1:0] vec_count;

   always_comb begin
      vec_count = '0;
      for (int i = 0; i < WIDTH; i++) begin
         vec_count = vec_count + CNT_WIDTH'(bus.i_vec[i]);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         remaining <= '0;
      end else if (in_hs) begin
         remaining <= vec_count;
      end else if (out_hs && (remaining != '0)) begin
         remaining <= remaining - CNT_WIDTH'(1);
      end
   end

   assign bus.o_remaining = remaining;
`endif

endmodule
`default_nettype wire

// File: tb/tb_std_bitvec_index_serializer.sv
`default_nettype none
// tb_std_bitvec_index_serializer : drives an LSB-first and an MSB-first instance
// with identical traffic and compares both against a queue-based reference.
module tb_std_bitvec_index_serializer;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   std_bitvec_index_serializer_if #(.WIDTH(WIDTH)) bus_lo ();
   std_bitvec_index_serializer_if #(.WIDTH(WIDTH)) bus_hi ();

   std_bitvec_index_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lo (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus_lo)
   );

   std_bitvec_index_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_hi (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus_hi)
   );

   int checks = 0;
   int errors = 0;

   // Beats still owed for the current vector, in emission order per direction
   int lo_q[$];
   int hi_q[$];
   bit empty_vec = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] vec, input logic rdy);
      int n;
      bit busy;
      bit exp_last;
      bit exp_ready;
      int exp_lo;
      int exp_hi;
      rst            = r;
      bus_lo.i_valid = v;
      bus_lo.i_vec   = vec;
      bus_lo.i_ready = rdy;
      bus_hi.i_valid = v;
      bus_hi.i_vec   = vec;
      bus_hi.i_ready = rdy;
      #1;
      n         = lo_q.size();
      busy      = (n != 0);
      exp_last  = (n == 1);
      exp_ready = !busy || (rdy && exp_last);
      exp_lo    = 0;
      exp_hi    = 0;
      if (busy) begin
         exp_lo = lo_q[0];
         exp_hi = hi_q[0];
      end
      check("lo_valid", 32'(bus_lo.o_valid), 32'(busy));
      check("lo_ready", 32'(bus_lo.o_ready), 32'(exp_ready));
      check("lo_index", 32'(bus_lo.o_index), exp_lo);
      check("lo_last",  32'(bus_lo.o_last),  32'(exp_last));
      check("lo_empty", 32'(bus_lo.o_empty), 32'(busy && empty_vec));
      check("hi_valid", 32'(bus_hi.o_valid), 32'(busy));
      check("hi_ready", 32'(bus_hi.o_ready), 32'(exp_ready));
      check("hi_index", 32'(bus_hi.o_index), exp_hi);
      check("hi_last",  32'(bus_hi.o_last),  32'(exp_last));
      check("hi_empty", 32'(bus_hi.o_empty), 32'(busy && empty_vec));
`ifdef STD_BITVEC_SERIALIZER_POPCOUNT_EN
      check("lo_remaining", 32'(bus_lo.o_remaining), (busy && !empty_vec) ? n : 0);
      check("hi_remaining", 32'(bus_hi.o_remaining), (busy && !empty_vec) ? n : 0);
`endif
      if (r) begin
         lo_q.delete();
         hi_q.delete();
         empty_vec = 1'b0;
      end else begin
         if (busy && rdy) begin
            void'(lo_q.pop_front());
            void'(hi_q.pop_front());
            if (lo_q.size() == 0) empty_vec = 1'b0;
         end
         if (v && exp_ready) begin
            if (vec == '0) begin
               lo_q.push_back(0);
               hi_q.push_back(0);
               empty_vec = 1'b1;
            end else begin
               empty_vec = 1'b0;
               for (int i = 0; i < WIDTH; i++) begin
                  if (vec[i]) begin
                     lo_q.push_back(i);
                     hi_q.push_front(i);
                  end
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [WIDTH-1:0] rvec;
      logic             rrdy;
      int               stall;
      rst            = 1'b1;
      bus_lo.i_valid = 1'b0;
      bus_lo.i_vec   = '0;
      bus_lo.i_ready = 1'b0;
      bus_hi.i_valid = 1'b0;
      bus_hi.i_vec   = '0;
      bus_hi.i_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state, then the basic 8'b1010_0100 walk in both directions
      step(1'b0, 1'b1, 8'b1010_0100, 1'b1);
      repeat (4) step(1'b0, 1'b0, '0, 1'b1);

      // All-zero vector
      step(1'b0, 1'b1, 8'h00, 1'b1);
      repeat (2) step(1'b0, 1'b0, '0, 1'b1);

      // Back-pressure mid-vector with i_valid asserted
      step(1'b0, 1'b1, 8'hF0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1);
      repeat (4) step(1'b0, 1'b1, 8'h55, 1'b0);
      repeat (4) step(1'b0, 1'b0, '0, 1'b1);

      // Back-to-back vectors
      step(1'b0, 1'b1, 8'h81, 1'b1);
      repeat (2) step(1'b0, 1'b1, 8'h10, 1'b1);
      repeat (2) step(1'b0, 1'b0, '0, 1'b1);

      // Reset after first beat; handshake during reset is dropped
      step(1'b0, 1'b1, 8'hFF, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1);
      step(1'b1, 1'b1, 8'h3C, 1'b1);
      step(1'b0, 1'b1, 8'h02, 1'b1);
      repeat (2) step(1'b0, 1'b0, '0, 1'b1);

      stall = 0;
      for (int c = 0; c < 3000; c++) begin
         case ($urandom_range(7))
            0:       rvec = '0;
            1:       rvec = '1;
            2:       rvec = WIDTH'(1) << $urandom_range(WIDTH - 1);
            default: rvec = WIDTH'($urandom);
         endcase
         if (stall == 0 && $urandom_range(30) == 0) stall = $urandom_range(6, 1);
         if (stall != 0) begin
            rrdy = 1'b0;
            stall--;
         end else begin
            rrdy = ($urandom_range(3) != 0);
         end
         step(($urandom_range(149) == 0), ($urandom_range(9) < 7), rvec, rrdy);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/std_bitvec_index_serializer.md
Name: std_bitvec_index_serializer

Overview:
- Streaming successor to the one-hot binary encoder. Accepts an arbitrary multi-hot bit vector on a valid/ready input and emits the binary index of every set bit, one index per output beat, in priority order.
- Used wherever a multi-hot request, pending or dirty mask must be walked sequentially, for example by writeback or interrupt-drain logic.
- Generalises the encoder to multi-hot input, selectable scan direction, back-pressure and an end-of-vector marker.

Parameters:
- WIDTH, 256, width of the input bit vector; legal range is WIDTH >= 2.
- MSB_FIRST, 0, scan direction. 0: lowest set index is emitted first. 1: highest set index is emitted first.
- INDEX_WIDTH (localparam), $clog2(WIDTH), width of the emitted index.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_valid  input  1  input vector valid.
- o_ready  output  1  block can accept a vector this cycle.
- i_vec  input  WIDTH  multi-hot vector; sampled only on input handshake.
- o_valid  output  1  output beat valid.
- i_ready  input  1  downstream accepts the beat.
- o_index  output  INDEX_WIDTH  index of the current set bit.
- o_last  output  1  current beat is the final beat for this vector.
- o_empty  output  1  the accepted vector was all-zero; this beat carries no index.

Behaviour:
- Reset: one clock, synchronous and active-high. All registers update on the i_clk rising edge, and i_rst is sampled there.
- Reset state:
  - state = IDLE, pending = 0, empty_q = 0.
  - Outputs after reset: o_valid=0, o_ready=1, o_index=0, o_last=0, o_empty=0.
- Reset mid-operation: any in-flight vector is discarded. No further beats are emitted for it, and a handshake occurring in the reset cycle is ignored.
- State machine: two states, IDLE and BUSY.
  - o_valid = (state==BUSY).
  - o_ready = (state==IDLE) | (state==BUSY & i_ready & o_last).
- Input handshake (i_valid & o_ready):
  - pending <= i_vec, empty_q <= (i_vec==0), state <= BUSY.
  - The first beat is valid exactly 1 cycle after the input handshake.
- Output beat, combinational from registers only (no combinational path from i_valid or i_vec):
  - o_index = lowest set bit of pending, or highest if MSB_FIRST=1.
  - o_last = pending has at most one bit set.
  - o_empty = empty_q.
- Output handshake (o_valid & i_ready):
  - The bit at o_index is cleared in pending.
  - If o_last=1: state <= IDLE, unless a new input handshake happens in the same cycle (back-to-back case below).
- All-zero vector: produces exactly one beat with o_index=0, o_last=1, o_empty=1.
- Back-to-back: a final-beat handshake and an input handshake in the same cycle load the new vector and stay in BUSY. This gives zero idle cycles between vectors.
- Hold rule: while o_valid=1 and i_ready=0, o_index, o_last and o_empty stay stable.
- Input sampling: i_vec is ignored outside the input handshake cycle.
- Throughput: 1 index per cycle with i_ready held high. A vector with k set bits takes max(k,1) beats.
- Width rule: the all-ones vector with WIDTH=256 emits 256 beats, with indices 0..255 for MSB_FIRST=0.

Optional Feature:
- Macro: STD_BITVEC_SERIALIZER_POPCOUNT_EN.
- When defined:
  - Adds output o_remaining, width INDEX_WIDTH+1, equal to the number of set bits in pending, including the current beat.
  - o_remaining is registered: loaded with popcount(i_vec) on input handshake and decremented on each output handshake.
  - o_remaining = 0 in IDLE, after reset, and during an o_empty beat.
- When undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset, WIDTH=8, MSB_FIRST=0, i_vec=8'b1010_0100, i_ready=1 -> beats at cycles 1-3 are indices 2, 5, 7; o_last=1 only on index 7; o_ready=1 in cycle 3.
- Same vector, MSB_FIRST=1 -> indices 7, 5, 2; the final beat has o_last=1.
- i_vec=0 -> one beat with o_index=0, o_empty=1, o_last=1; then return to IDLE.
- Back-pressure: i_ready=0 for 4 cycles mid-vector -> o_index, o_last and o_empty stay stable, no beat is lost or duplicated, and o_ready stays 0.
- Back-to-back: 8'h81 then 8'h10 with i_valid held high -> beats 0, 7, 4 on consecutive cycles with no bubble.
- Reset asserted after the first beat of 8'hFF, then new vector 8'h02 -> only index 1 is emitted afterwards. With POPCOUNT_EN, o_remaining sequence for 8'hFF is 8, 7, …, and it reads 0 after reset.
